// File: rtl/sad_pkg.sv
// rtl/sad_pkg.sv - shared constants and state encoding for the SAD loader and engine
//
// Purpose: one place for the SAD address/data widths, default block length
// and the loader state encoding.
// Optional build macro: SAD_LOADER_INTERLEAVE_EN (collapses LOAD_A/LOAD_B
// into a single LOAD state for A0,B0,A1,B1,... stream order).
package sad_pkg;

  localparam int SAD_ADDR_W    = 9;
  localparam int SAD_DATA_W    = 8;
  localparam int SAD_BLOCK_LEN = 256;

`ifdef SAD_LOADER_INTERLEAVE_EN
  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    FLUSH,
    GO
  } sad_state_t;
`else
  typedef enum logic [2:0] {
    IDLE,
    LOAD_A,
    LOAD_B,
    FLUSH,
    GO
  } sad_state_t;
`endif

endpackage

// File: rtl/sad_loader_counter.sv
// rtl/sad_loader_counter.sv - block address counter with terminal-count flag
//
// Purpose: counts accepted beats from 0 up to TERMINAL, then wraps to 0 on
// the next enabled cycle. Never exceeds TERMINAL.
// Ports:
//   clk    in   system clock, rising edge
//   rst    in   asynchronous active-high reset (count -> 0)
//   en     in   advance the count this cycle
//   clr    in   synchronous clear to 0 (wins over en)
//   count  out  ADDR_W current address
//   last   out  high when count == TERMINAL
module sad_loader_counter
  import sad_pkg::*;
#(
  parameter int ADDR_W   = SAD_ADDR_W,
  parameter int TERMINAL = SAD_BLOCK_LEN - 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              clr,
  output logic [ADDR_W-1:0] count,
  output logic              last
);

  localparam logic [ADDR_W-1:0] TERM_V = ADDR_W'(TERMINAL);

  assign last = (count == TERM_V);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= last ? '0 : count + ADDR_W'(1);
    end
  end

endmodule

// File: rtl/sad_block_loader.sv
// rtl/sad_block_loader.sv - stream-to-block-RAM loader for the SAD datapath
//
// Purpose: accepts BLOCK_LEN bytes into block A then BLOCK_LEN bytes into
// block B over a valid/ready handshake, then pulses go once the final write
// has landed.
// Optional build macro: SAD_LOADER_INTERLEAVE_EN (stream order A0,B0,A1,B1,...).
// Ports:
//   clk       in   system clock, rising edge
//   Mrst      in   asynchronous active-high master reset
//   start     in   begin a load, sampled only in IDLE
//   in_data   in   DATA_W stream byte
//   in_valid  in   in_data valid
//   in_ready  out  loader accepts a byte this cycle (state only)
//   wr_addr   out  ADDR_W registered memory write address
//   wr_data   out  DATA_W registered memory write data
//   we_a      out  registered write strobe, block A
//   we_b      out  registered write strobe, block B
//   go        out  one-cycle start pulse to the SAD FSM
//   busy      out  high in any state except IDLE
module sad_block_loader
  import sad_pkg::*;
#(
  parameter int BLOCK_LEN = SAD_BLOCK_LEN,
  parameter int DATA_W    = SAD_DATA_W,
  parameter int ADDR_W    = SAD_ADDR_W
) (
  input  logic              clk,
  input  logic              Mrst,
  input  logic              start,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              we_a,
  output logic              we_b,
  output logic              go,
  output logic              busy
);

  sad_state_t        state;
  logic              accept;
  logic              cnt_en;
  logic              cnt_clr;
  logic [ADDR_W-1:0] count;
  logic              last;

`ifdef SAD_LOADER_INTERLEAVE_EN
  // 0: current beat targets block A, 1: block B
  logic phase;

  assign in_ready = (state == LOAD);
  // Both beats of an A/B pair share one address, so advance after B only.
  assign cnt_en   = accept && phase;
`else
  assign in_ready = (state == LOAD_A) || (state == LOAD_B);
  assign cnt_en   = accept;
`endif

  assign accept  = in_valid && in_ready;
  assign busy    = (state != IDLE);
  // Counter already sits at 0 in IDLE; the clear only guards the start of a load.
  assign cnt_clr = (state == IDLE) && start;

  sad_loader_counter #(
    .ADDR_W  (ADDR_W),
    .TERMINAL(BLOCK_LEN - 1)
  ) u_counter (
    .clk  (clk),
    .rst  (Mrst),
    .en   (cnt_en),
    .clr  (cnt_clr),
    .count(count),
    .last (last)
  );

  always_ff @(posedge clk or posedge Mrst) begin
    if (Mrst) begin
      state   <= IDLE;
      wr_addr <= '0;
      wr_data <= '0;
      we_a    <= 1'b0;
      we_b    <= 1'b0;
      go      <= 1'b0;
`ifdef SAD_LOADER_INTERLEAVE_EN
      phase   <= 1'b0;
`endif
    end else begin
      we_a <= 1'b0;
      we_b <= 1'b0;
      go   <= 1'b0;

      // Address/data only move on an accepted beat and otherwise hold.
      if (accept) begin
        wr_addr <= count;
        wr_data <= in_data;
      end

      case (state)
        IDLE: begin
          if (start) begin
`ifdef SAD_LOADER_INTERLEAVE_EN
            state <= LOAD;
            phase <= 1'b0;
`else
            state <= LOAD_A;
`endif
          end
        end
`ifdef SAD_LOADER_INTERLEAVE_EN
        LOAD: begin
          if (accept) begin
            phase <= ~phase;
            if (!phase) begin
              we_a <= 1'b1;
            end else begin
              we_b <= 1'b1;
              if (last) state <= FLUSH;
            end
          end
        end
`else
        LOAD_A: begin
          if (accept) begin
            we_a <= 1'b1;
            if (last) state <= LOAD_B;
          end
        end
        LOAD_B: begin
          if (accept) begin
            we_b <= 1'b1;
            if (last) state <= FLUSH;
          end
        end
`endif
        // The final B write is on the bus during FLUSH; go follows it.
        FLUSH: begin
          state <= GO;
          go    <= 1'b1;
        end
        GO: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/sad_block_loader.md
Name: sad_block_loader

Overview:
- Write-side producer for the SAD datapath. Accepts a byte stream over a valid/ready handshake.
- Writes BLOCK_LEN bytes into block memory A, then BLOCK_LEN bytes into block memory B, over a shared 9-bit address bus.
- After the last write it issues a one-cycle go pulse to the SAD FSM.
- Sits between the pixel source and the A/B block RAMs that the SAD engine reads.

Parameters:
- BLOCK_LEN, 256, entries per block. Legal range 1..512.
- DATA_W, 8, byte width of stream and memory data.
- ADDR_W, 9, width of wr_addr. Matches the SAD address bus.

Ports:
- clk  in  1  system clock, rising edge
- Mrst  in  1  asynchronous, active-high master reset
- start  in  1  begin a load. Sampled only in IDLE.
- in_data  in  DATA_W  stream byte
- in_valid  in  1  in_data valid
- in_ready  out  1  loader can accept a byte this cycle
- wr_addr  out  ADDR_W  memory write address, registered
- wr_data  out  DATA_W  memory write data, registered
- we_a  out  1  write strobe for block A, registered
- we_b  out  1  write strobe for block B, registered
- go  out  1  one-cycle start pulse to SAD FSM
- busy  out  1  high in any state except IDLE

Behaviour:
- Reset (Mrst=1, async): state=IDLE, address counter=0. All outputs are 0: in_ready, wr_addr, wr_data, we_a, we_b, go, busy.
- States and transitions:
  - IDLE → LOAD_A on start=1.
  - LOAD_A → LOAD_B after BLOCK_LEN accepted beats.
  - LOAD_B → FLUSH after BLOCK_LEN accepted beats.
  - FLUSH → GO after 1 cycle.
  - GO → IDLE after 1 cycle.
- in_ready is combinational: in_ready = (state==LOAD_A || state==LOAD_B). It does not depend on in_valid.
- A beat is accepted on a rising clk edge where in_valid && in_ready.
- On an accepted beat:
  - The next cycle has wr_addr = counter, wr_data = in_data.
  - we_a=1 if the beat was accepted in LOAD_A; we_b=1 if accepted in LOAD_B.
  - Write latency is exactly 1 cycle. we_a/we_b are otherwise 0, and are never both 1.
- Counter:
  - 9 bits, starts at 0.
  - Increments per accepted beat.
  - Clears to 0 when the beat with counter==BLOCK_LEN-1 is accepted (the A→B transition and the B→FLUSH transition).
  - Does not wrap beyond BLOCK_LEN-1.
- FLUSH exists so the final B write lands before go. For a last B beat accepted at edge t:
  - we_b=1 during cycle t+1 (FLUSH).
  - go=1 during cycle t+2 (GO).
  - busy falls at t+3.
- Bubbles: in_valid=0 stalls with no write and no counter change. Stalls of any length are allowed.
- start=1 while busy is ignored. start held high continuously restarts a load on the cycle after GO→IDLE.
- in_data/in_valid presented in IDLE, FLUSH or GO are not accepted (in_ready=0).
- Mrst mid-load aborts immediately:
  - Partial memory contents are left as is.
  - No go is issued.
  - The next start restarts at A address 0.
- BLOCK_LEN=1: one A beat, one B beat, then FLUSH and GO.
- Wr_addr/wr_data hold their last value when no strobe is active. Do not rely on them.

Optional Feature:
- Macro SAD_LOADER_INTERLEAVE_EN.
- Defined:
  - Stream order is A0,B0,A1,B1,…
  - A single LOAD state replaces LOAD_A/LOAD_B. A 1-bit phase flag selects we_a (phase 0) or we_b (phase 1).
  - The counter increments after each B beat.
  - LOAD → FLUSH after 2·BLOCK_LEN beats.
  - All other timing is unchanged.
- Undefined: block-sequential order as specified above.

Decomposition:
- Shared package sad_pkg holds:
  - state encoding typedef (IDLE, LOAD_A, LOAD_B, FLUSH, GO; LOAD under interleave)
  - SAD_ADDR_W=9, SAD_DATA_W=8, SAD_BLOCK_LEN=256
- The SAD side reuses the same constants.
- One natural sub-module: sad_loader_counter.
  - Inputs: en, clr.
  - Output: 9-bit address, plus a last flag when count==BLOCK_LEN-1.
  - Same shape as the SAD counter, with a parameterised terminal value.

Test Plan:
- Reset, then start with BLOCK_LEN=256 and back-to-back stream of bytes k&0xFF (k=0..511) → we_a for addr 0..255 with data 0..255, then we_b for addr 0..255 with data 0..255, single go at 2 cycles after last accept, busy low after.
- Same load with in_valid toggling 1/0 every cycle → identical write sequence, no lost or duplicated address, go only after 512th beat's write.
- start pulsed at beat 100 of LOAD_A, and in_valid=1 during IDLE/FLUSH/GO → start ignored; in_ready=0 and no writes outside LOAD states.
- Mrst asserted after A addr 37 written → all outputs 0 within same cycle, no go. Re-start → first write is we_a addr 0.
- BLOCK_LEN=1, stream 0xAA,0x55 → we_a addr0=0xAA, we_b addr0=0x55, go 2 cycles after second accept.
- SAD_LOADER_INTERLEAVE_EN, BLOCK_LEN=4, stream 1..8 → A[0..3]=1,3,5,7 and B[0..3]=2,4,6,8, strobes alternating, one go.
